// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised single-port RAM.
//   RDW_READ_FIRST / RDW_WRITE_FIRST : read-during-write mode selectors
//   state_t                          : sequencer states (ST_CLEAR, ST_RUN)
//   merge_byte()                     : byte-lane select used for be masking
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // One byte lane of a masked write: new byte when enabled, else old byte.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       lane_en);
    return lane_en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational byte-enable merge of a write word into an existing word.
// Ports:
//   old_word : current stored word
//   new_word : incoming write data
//   be       : byte enables, bit i selects new_word byte i
//   merged   : resulting word
module ram_byte_merge
  import ram_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  localparam int NB = DATA_W / 8;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      merged[8*i +: 8] = merge_byte(old_word[8*i +: 8], new_word[8*i +: 8], be[i]);
    end
  end

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, optional output register and a post-reset
// clear sweep.
// Ports:
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   en, wr    : access request and direction (1 = write)
//   addr      : word address
//   data_in   : write data, be selects which bytes are written
//   data_out  : registered read data (also updated by writes)
//   rd_valid  : one-cycle strobe marking data_out of a read
//   busy      : clear sweep in progress, requests ignored
//   err       : one-cycle strobe, access to addr >= DEPTH
// Handshake: an access is accepted on any rising edge where en = 1 and busy = 0;
// there is no backpressure. Its result appears 1 (OUT_REG = 0) or 2
// (OUT_REG = 1) edges later, with rd_valid/err aligned to data_out.
module ram_sync_param
  import ram_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int RDW_MODE     = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy,
  output logic                err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   cnt;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic                accept;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   rd_word;

  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   s1_data;
  logic                s1_valid;
  logic                s1_err;

  assign in_range = ({1'b0, addr} < DEPTH_A);
  assign accept   = (state == ST_RUN) && en;
  assign old_word = mem[addr[IDX_W-1:0]];

  ram_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (old_word),
    .new_word (data_in),
    .be       (be),
    .merged   (merged)
  );

  // Value loaded into the data stage; out-of-range accesses return zero.
  always_comb begin
    rd_word = old_word;
    if (!in_range) begin
      rd_word = '0;
    end else if (wr && (RDW_MODE == RDW_WRITE_FIRST)) begin
      rd_word = merged;
    end
  end

  // Single write port shared by the clear sweep and normal writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = addr[IDX_W-1:0];
    mem_wdata = merged;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = cnt[IDX_W-1:0];
      mem_wdata = CLEAR_VAL;
    end else if (accept && wr && in_range) begin
      mem_we    = 1'b1;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  // Sequencer: sweep CLEAR_VAL through every word, then serve accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      cnt   <= '0;
      busy  <= (CLEAR_ON_RST != 0);
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state <= ST_RUN;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // First data stage: data holds when idle, strobes are single-cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else if (accept) begin
      s1_data  <= rd_word;
      s1_valid <= !wr;
      s1_err   <= !in_range;
    end else begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out <= '0;
          rd_valid <= 1'b0;
          err      <= 1'b0;
        end else begin
          data_out <= s1_data;
          rd_valid <= s1_valid;
          err      <= s1_err;
        end
      end
    end else begin : g_no_out_reg
      assign data_out = s1_data;
      assign rd_valid = s1_valid;
      assign err      = s1_err;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sync_param.sv
module tb_ram_sync_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  // DUT A: 256x8, read-first, latency 1, clear to A5
  logic        en_a = 1'b0, wr_a = 1'b0;
  logic [7:0]  addr_a = '0, din_a = '0;
  logic        be_a = 1'b0;
  logic [7:0]  data_out_a;
  logic        rd_valid_a, busy_a, err_a;

  // DUT B: 200x16, write-first, latency 2, clear to 0F0F
  logic        en_b = 1'b0, wr_b = 1'b0;
  logic [7:0]  addr_b = '0;
  logic [15:0] din_b = '0;
  logic [1:0]  be_b = '0;
  logic [15:0] data_out_b;
  logic        rd_valid_b, busy_b, err_b;

  ram_sync_param #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(256), .RDW_MODE(0), .OUT_REG(0),
    .CLEAR_ON_RST(1), .CLEAR_VAL(8'hA5)
  ) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .wr(wr_a), .addr(addr_a),
    .data_in(din_a), .be(be_a), .data_out(data_out_a),
    .rd_valid(rd_valid_a), .busy(busy_a), .err(err_a)
  );

  ram_sync_param #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(200), .RDW_MODE(1), .OUT_REG(1),
    .CLEAR_ON_RST(1), .CLEAR_VAL(16'h0F0F)
  ) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .wr(wr_b), .addr(addr_b),
    .data_in(din_b), .be(be_b), .data_out(data_out_b),
    .rd_valid(rd_valid_b), .busy(busy_b), .err(err_b)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {err, rd_valid, data[15:0]}
  logic [17:0] exp_a_q[$];
  logic [17:0] exp_b_q[$];
  logic        acc_a = 1'b0, acc_b = 1'b0;
  logic [0:0]  pipe_a = '0;
  logic [1:0]  pipe_b = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Track when each accepted access is due at the outputs.
  always @(posedge clk) begin
    pipe_a = acc_a;
    pipe_b = {pipe_b[0], acc_b};
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (pipe_a[0]) begin
      if (exp_a_q.size() == 0) begin
        check("a_queue_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_a_q.pop_front();
        check("a_data", 32'(data_out_a), 32'(e[7:0]));
        check("a_rd_valid", 32'(rd_valid_a), 32'(e[16]));
        check("a_err", 32'(err_a), 32'(e[17]));
      end
    end else begin
      check("a_idle_strobes", 32'({rd_valid_a, err_a}), 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (pipe_b[1]) begin
      if (exp_b_q.size() == 0) begin
        check("b_queue_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_b_q.pop_front();
        check("b_data", 32'(data_out_b), 32'(e[15:0]));
        check("b_rd_valid", 32'(rd_valid_b), 32'(e[16]));
        check("b_err", 32'(err_b), 32'(e[17]));
      end
    end else begin
      check("b_idle_strobes", 32'({rd_valid_b, err_b}), 32'd0);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_a(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic b, input logic [7:0] exp_d, input logic exp_e);
    @(negedge clk);
    en_a = 1'b1; wr_a = w; addr_a = a; din_a = d; be_a = b; acc_a = 1'b1;
    exp_a_q.push_back({exp_e, ~w, 8'h00, exp_d});
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      en_a = 1'b0; wr_a = 1'b0; acc_a = 1'b0;
    end
  endtask

  task automatic drive_b(input logic w, input logic [7:0] a, input logic [15:0] d,
                         input logic [1:0] b, input logic [15:0] exp_d, input logic exp_e);
    @(negedge clk);
    en_b = 1'b1; wr_b = w; addr_b = a; din_b = d; be_b = b; acc_b = 1'b1;
    exp_b_q.push_back({exp_e, ~w, exp_d});
  endtask

  task automatic idle_b(input int n);
    repeat (n) begin
      @(negedge clk);
      en_b = 1'b0; wr_b = 1'b0; acc_b = 1'b0;
    end
  endtask

  // Busy cycles counted from the reset-release negedge; bounded.
  task automatic busy_len_a(output int n);
    n = 0;
    while (busy_a && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic busy_len_b(output int n);
    n = 0;
    while (busy_b && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;

    repeat (3) @(negedge clk);
    check("a_reset_data", 32'(data_out_a), 32'd0);
    check("a_reset_busy", 32'(busy_a), 32'd1);
    check("b_reset_data", 32'(data_out_b), 32'd0);
    check("b_reset_busy", 32'(busy_b), 32'd1);

    // ---- DUT A: clear sweep length then basic traffic ----
    rst_a = 1'b0;
    busy_len_a(n);
    check("a_clear_cycles", 32'(n), 32'd256);

    drive_a(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b0);
    drive_a(1'b0, 8'hFF, 8'h00, 1'b1, 8'hA5, 1'b0);
    drive_a(1'b1, 8'h10, 8'h3C, 1'b1, 8'hA5, 1'b0);   // read-first: old word
    drive_a(1'b0, 8'h10, 8'h00, 1'b1, 8'h3C, 1'b0);
    drive_a(1'b1, 8'h20, 8'h11, 1'b1, 8'hA5, 1'b0);
    drive_a(1'b1, 8'h20, 8'h22, 1'b1, 8'h11, 1'b0);
    drive_a(1'b0, 8'h20, 8'h00, 1'b1, 8'h22, 1'b0);
    drive_a(1'b1, 8'h10, 8'hFF, 1'b0, 8'h3C, 1'b0);   // be = 0 leaves word alone
    drive_a(1'b0, 8'h10, 8'h00, 1'b1, 8'h3C, 1'b0);
    idle_a(3);
    check("a_hold_when_idle", 32'(data_out_a), 32'h3C);

    // ---- DUT A: reset mid-sweep with writes requested throughout ----
    @(negedge clk);
    en_a = 1'b1; wr_a = 1'b1; addr_a = 8'h10; din_a = 8'h5A; be_a = 1'b1;
    rst_a = 1'b1;
    #1;
    check("a_rst_data", 32'(data_out_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (100) @(negedge clk);
    check("a_busy_mid_sweep", 32'(busy_a), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    busy_len_a(n);
    en_a = 1'b0; wr_a = 1'b0;
    check("a_restart_cycles", 32'(n), 32'd256);

    drive_a(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b0);
    drive_a(1'b0, 8'h20, 8'h00, 1'b1, 8'hA5, 1'b0);
    drive_a(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b0);
    drive_a(1'b0, 8'h80, 8'h00, 1'b1, 8'hA5, 1'b0);
    idle_a(3);

    // ---- DUT B: 16-bit, DEPTH 200, write-first, output register ----
    rst_b = 1'b0;
    busy_len_b(n);
    check("b_clear_cycles", 32'(n), 32'd200);

    drive_b(1'b1, 8'h10, 16'h003C, 2'b11, 16'h003C, 1'b0);  // write-first: new word
    drive_b(1'b0, 8'h10, 16'h0000, 2'b11, 16'h003C, 1'b0);
    drive_b(1'b1, 8'h05, 16'h1234, 2'b11, 16'h1234, 1'b0);
    drive_b(1'b1, 8'h05, 16'hABCD, 2'b10, 16'hAB34, 1'b0);
    drive_b(1'b0, 8'h05, 16'h0000, 2'b11, 16'hAB34, 1'b0);
    drive_b(1'b1, 8'h20, 16'h0011, 2'b11, 16'h0011, 1'b0);
    drive_b(1'b1, 8'h20, 16'h0022, 2'b11, 16'h0022, 1'b0);
    drive_b(1'b0, 8'h20, 16'h0000, 2'b11, 16'h0022, 1'b0);
    drive_b(1'b1, 8'd210, 16'h0077, 2'b11, 16'h0000, 1'b1); // out of range write
    drive_b(1'b0, 8'd210, 16'h0000, 2'b11, 16'h0000, 1'b1); // out of range read
    drive_b(1'b0, 8'd10, 16'h0000, 2'b11, 16'h0F0F, 1'b0);  // alias word untouched
    drive_b(1'b0, 8'd199, 16'h0000, 2'b11, 16'h0F0F, 1'b0); // last word
    drive_b(1'b1, 8'd199, 16'h5566, 2'b01, 16'h0F66, 1'b0);
    drive_b(1'b0, 8'd199, 16'h0000, 2'b11, 16'h0F66, 1'b0);
    idle_b(4);
    check("b_hold_when_idle", 32'(data_out_b), 32'h0F66);

    check("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
